video_stream_pattern_gen: RTL and testbench
===========================================

// Module: video_stream_pattern_gen
//
// PURPOSE
//  Synthesizable source for the multi-pixel-per-clock video stream protocol: per-pixel valid mask
//  and line/frame start/end markers. Generates full frame timing (active area plus blanking) and
//  one of four test patterns. It replaces file-driven stimulus in front of video_stream_to_window
//  and other stream consumers, both on-chip and in benches.
//
// PARAMETERS
//  PX_WIDTH    12    bits per pixel
//  PX_PER_CLK  4     pixels per word (lane 0 = leftmost pixel)
//  RES_X       1936  active pixels per line
//  RES_Y       1096  active lines per frame
//  TOTAL_X     2200  total pixels per line incl. blanking; must be a multiple of PX_PER_CLK
//                    and TOTAL_X/PX_PER_CLK > ceil(RES_X/PX_PER_CLK)
//  TOTAL_Y     1125  total lines per frame incl. blanking; TOTAL_Y > RES_Y
//
// PORTS
//  clk_i          in   1                     clock
//  rst_i          in   1                     async reset, active-high
//  en_i           in   1                     run request; sampled at frame boundaries only
//  pattern_i      in   2                     0 h-ramp, 1 v-ramp, 2 checker, 3 frame-count solid
//  px_data_o      out  PX_PER_CLK*PX_WIDTH   pixel word, lane i = pixel x*PX_PER_CLK+i
//  px_data_val_o  out  PX_PER_CLK            per-lane valid mask
//  line_start_o   out  1                     first word of an active line
//  line_end_o     out  1                     last word of an active line
//  frame_start_o  out  1                     first word of a frame (x=0,y=0)
//  frame_end_o    out  1                     last word of last active line
//  busy_o         out  1                     1 while a frame is being emitted (RUN state)
//
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters x=y=0, frame_cnt=0. Asserting reset mid-frame
//    aborts the frame immediately; no end markers are emitted.
//  - WPL = ceil(RES_X/PX_PER_CLK); LW = TOTAL_X/PX_PER_CLK words per line; REM = RES_X%PX_PER_CLK.
//  - FSM IDLE->RUN when en_i=1 at posedge N; word (x=0,y=0) with frame_start_o is on the outputs
//    after posedge N+1. Emits exactly one word per clock, no gaps or backpressure.
//  - In RUN, x counts 0..LW-1 and y counts 0..TOTAL_Y-1. On the last word (x=LW-1, y=TOTAL_Y-1):
//    en_i=1 -> next frame starts on the next cycle (back-to-back, frame_cnt+1);
//    en_i=0 -> IDLE (frame_cnt+1). en_i changes mid-frame have no effect.
//  - pattern_i is latched at the frame_start word. The latched value holds for the whole frame.
//  - Active word (y<RES_Y, x<WPL): px_data_val_o='1, except at x=WPL-1 with REM>0, where it is
//    (1<<REM)-1 (low lanes valid). Invalid lanes carry data 0.
//    line_start_o=(x==0); line_end_o=(x==WPL-1), so both are set together when WPL=1.
//    frame_start_o=(x==0 && y==0); frame_end_o=(x==WPL-1 && y==RES_Y-1).
//  - Blanking word: data, val and all markers are 0.
//  - Pixel value for column p=x*PX_PER_CLK+i, row y, truncated to PX_WIDTH bits:
//    0: p; 1: y; 2: ((p>>3)^(y>>3))&1 ? all-ones : 0; 3: frame_cnt.
//  - frame_cnt is PX_WIDTH bits and wraps at 2^PX_WIDTH. All outputs are registered (no comb paths).
//
// TESTING (bench params: PX_PER_CLK=4, RES_X=10, TOTAL_X=16, RES_Y=3, TOTAL_Y=5, PX_WIDTH=12)
//  1. Reset, en_i=1 one cycle, pattern 0 -> line words val 4'hF,4'hF,4'h3,0; lane data 0..9 then
//     0; line_start on word 0, line_end on word 2; 20-cycle frame; busy_o falls after the frame.
//  2. en_i held 1, pattern 3 -> consecutive frames with no idle cycle; solid data 0,1,2 per frame;
//     exactly one frame_start and one frame_end per 20 cycles; frame_end at y=2 word 2.
//  3. Toggle pattern_i and en_i mid-frame -> current frame unchanged; new pattern appears only
//     from the next frame_start.
//  4. Pattern 2 with RES_X=32, PX_PER_CLK=4 -> lanes 0-7 of row 0 are 0, lanes 8-15 are 12'hFFF;
//     row 8 is inverted.
//  5. Assert rst_i mid-line (x=1, y=1) -> all outputs 0 immediately (async); after release with
//     en_i=1 the stream restarts at frame_start, y=0.
//  6. RES_X=4 (WPL=1, REM=0) -> line_start_o and line_end_o are both 1 on the same word, val 4'hF.

Source files
------------

// File: rtl/video_stream_pattern_gen.sv
// Test-pattern source for the multi-pixel-per-clock video stream: full frame timing with blanking,
// per-lane valid mask, line/frame markers and one of four selectable patterns.
module video_stream_pattern_gen #(
    parameter int PX_WIDTH   = 12,
    parameter int PX_PER_CLK = 4,
    parameter int RES_X      = 1936,
    parameter int RES_Y      = 1096,
    parameter int TOTAL_X    = 2200,
    parameter int TOTAL_Y    = 1125
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [1:0]                     pattern_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           busy_o
);

    localparam int WPL = (RES_X + PX_PER_CLK - 1) / PX_PER_CLK;
    localparam int LW  = TOTAL_X / PX_PER_CLK;
    localparam int REM = RES_X % PX_PER_CLK;
    localparam int XW  = (LW > 1) ? $clog2(LW) : 1;
    localparam int YW  = (TOTAL_Y > 1) ? $clog2(TOTAL_Y) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(LW - 1);
    localparam logic [XW-1:0] X_WPL      = XW'(WPL);
    localparam logic [XW-1:0] X_WPL_LAST = XW'(WPL - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(TOTAL_Y - 1);
    localparam logic [YW-1:0] Y_RES      = YW'(RES_Y);
    localparam logic [YW-1:0] Y_RES_LAST = YW'(RES_Y - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                          state, next_state;
    logic [XW-1:0]                   x_cnt;
    logic [YW-1:0]                   y_cnt;
    logic [PX_WIDTH-1:0]             frame_cnt;
    logic [1:0]                      pattern_q;
    logic [1:0]                      cur_pattern;
    logic                            first_word, last_word, in_active;
    logic [PX_WIDTH-1:0]             px_col, row;
    logic [PX_PER_CLK*PX_WIDTH-1:0]  word_data;
    logic [PX_PER_CLK-1:0]           word_val;

    assign first_word = (x_cnt == '0) && (y_cnt == '0);
    assign last_word  = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign in_active  = (state == RUN) && (y_cnt < Y_RES) && (x_cnt < X_WPL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // en_i only matters in IDLE and on the very last word of a frame
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en_i) next_state = RUN;
            RUN:     if (last_word && !en_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_cnt <= '0;
            pattern_q <= '0;
        end else if (state == RUN) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (last_word)  frame_cnt <= frame_cnt + 1'b1;
            if (first_word) pattern_q <= pattern_i;
        end
    end

    // The frame_start word already uses the incoming pattern; later words use the latched copy
    always_comb begin
        word_data   = '0;
        word_val    = '0;
        px_col      = '0;
        row         = PX_WIDTH'(y_cnt);
        cur_pattern = first_word ? pattern_i : pattern_q;
        for (int i = 0; i < PX_PER_CLK; i++) begin
            px_col = PX_WIDTH'(32'(x_cnt) * 32'(PX_PER_CLK) + 32'(i));
            if (in_active && (x_cnt != X_WPL_LAST || REM == 0 || i < REM)) begin
                word_val[i] = 1'b1;
                case (cur_pattern)
                    2'd0:    word_data[i*PX_WIDTH +: PX_WIDTH] = px_col;
                    2'd1:    word_data[i*PX_WIDTH +: PX_WIDTH] = row;
                    2'd2:    word_data[i*PX_WIDTH +: PX_WIDTH] = {PX_WIDTH{px_col[3] ^ row[3]}};
                    default: word_data[i*PX_WIDTH +: PX_WIDTH] = frame_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            px_data_o     <= '0;
            px_data_val_o <= '0;
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            px_data_o     <= word_data;
            px_data_val_o <= word_val;
            line_start_o  <= in_active && (x_cnt == '0);
            line_end_o    <= in_active && (x_cnt == X_WPL_LAST);
            frame_start_o <= in_active && first_word;
            frame_end_o   <= in_active && (x_cnt == X_WPL_LAST) && (y_cnt == Y_RES_LAST);
            busy_o        <= (state == RUN);
        end
    end

endmodule

// File: tb/tb_video_stream_pattern_gen.sv
// Bench for video_stream_pattern_gen: vector table, frame-index reference model with random
// stimulus, and hand-written sequences for reset, checker and single-word-line corners.
module tb_video_stream_pattern_gen;

    localparam int PXW = 12;
    localparam int NPC = 4;
    localparam int RX  = 10;
    localparam int TX  = 16;
    localparam int RY  = 3;
    localparam int TY  = 5;
    localparam int LW  = TX / NPC;
    localparam int WPL = (RX + NPC - 1) / NPC;
    localparam int FW  = LW * TY;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en = 1'b0, en2 = 1'b0, en3 = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [47:0] data, data2, data3;
    logic [3:0]  val, val2, val3;
    logic        ls, le, fs, fe, busy;
    logic        ls2, le2, fs2, fe2, busy2;
    logic        ls3, le3, fs3, fe3, busy3;

    video_stream_pattern_gen #(.PX_WIDTH(PXW), .PX_PER_CLK(NPC), .RES_X(RX), .RES_Y(RY),
                               .TOTAL_X(TX), .TOTAL_Y(TY)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pattern_i(pat),
        .px_data_o(data), .px_data_val_o(val), .line_start_o(ls), .line_end_o(le),
        .frame_start_o(fs), .frame_end_o(fe), .busy_o(busy));

    video_stream_pattern_gen #(.PX_WIDTH(PXW), .PX_PER_CLK(NPC), .RES_X(32), .RES_Y(9),
                               .TOTAL_X(40), .TOTAL_Y(10)) dut_checker (
        .clk_i(clk), .rst_i(rst), .en_i(en2), .pattern_i(2'd2),
        .px_data_o(data2), .px_data_val_o(val2), .line_start_o(ls2), .line_end_o(le2),
        .frame_start_o(fs2), .frame_end_o(fe2), .busy_o(busy2));

    video_stream_pattern_gen #(.PX_WIDTH(PXW), .PX_PER_CLK(NPC), .RES_X(4), .RES_Y(2),
                               .TOTAL_X(8), .TOTAL_Y(3)) dut_narrow (
        .clk_i(clk), .rst_i(rst), .en_i(en3), .pattern_i(2'd0),
        .px_data_o(data3), .px_data_val_o(val3), .line_start_o(ls3), .line_end_o(le3),
        .frame_start_o(fs3), .frame_end_o(fe3), .busy_o(busy3));

    typedef struct packed {
        logic [47:0] data;
        logic [3:0]  val;
        logic        ls, le, fs, fe, busy;
    } out_t;

    typedef struct {
        logic       en;
        logic [1:0] pat;
        out_t       exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         m_next = -1;
    int         m_fc   = 0;
    logic [1:0] m_pat  = 2'd0;
    out_t       m_exp;
    vec_t       tbl[22];

    // Expected word for frame-local word index w, derived from pixel coordinates
    function automatic out_t expWord(input int w, input logic [1:0] p_sel, input int fc);
        out_t o;
        int x, y, p;
        o      = '0;
        o.busy = 1'b1;
        x      = w % LW;
        y      = w / LW;
        if (y < RY && x < WPL) begin
            o.ls = (x == 0);
            o.le = (x == WPL - 1);
            o.fs = (x == 0 && y == 0);
            o.fe = (x == WPL - 1 && y == RY - 1);
            for (int i = 0; i < NPC; i++) begin
                p = x * NPC + i;
                if (p < RX) begin
                    o.val[i] = 1'b1;
                    case (p_sel)
                        2'd0: o.data[i*PXW +: PXW] = 12'(p);
                        2'd1: o.data[i*PXW +: PXW] = 12'(y);
                        2'd2: o.data[i*PXW +: PXW] = (((p >> 3) ^ (y >> 3)) & 1) != 0 ? 12'hFFF : 12'h000;
                        default: o.data[i*PXW +: PXW] = 12'(fc % 4096);
                    endcase
                end
            end
        end
        return o;
    endfunction

    task automatic modelStep(input logic e, input logic [1:0] p_sel);
        m_exp = '0;
        if (m_next >= 0) begin
            if (m_next == 0) m_pat = p_sel;
            m_exp = expWord(m_next, m_pat, m_fc);
            if (m_next == FW - 1) begin
                m_fc++;
                m_next = e ? 0 : -1;
            end else begin
                m_next++;
            end
        end else if (e) begin
            m_next = 0;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] p_sel);
        en  = e;
        pat = p_sel;
        modelStep(e, p_sel);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t a;
        a = '{data: data, val: val, ls: ls, le: le, fs: fs, fe: fe, busy: busy};
        checks++;
        if (a !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual data=%h val=%h ls=%b le=%b fs=%b fe=%b busy=%b required data=%h val=%h ls=%b le=%b fs=%b fe=%b busy=%b",
                     name, $time, a.data, a.val, a.ls, a.le, a.fs, a.fe, a.busy,
                     exp.data, exp.val, exp.ls, exp.le, exp.fs, exp.fe, exp.busy);
        end
    endtask

    task automatic checkBits(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic resetAll();
        en = 1'b0; en2 = 1'b0; en3 = 1'b0; pat = 2'd0;
        rst = 1'b1;
        m_next = -1; m_fc = 0; m_pat = 2'd0;
        @(posedge clk);
        #1;
        checkOutput("reset_state", '0);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic e, input logic [47:0] d, input logic [3:0] v,
                                input logic l_s, input logic l_e, input logic f_s,
                                input logic f_e, input logic b);
        vec_t r;
        r.en  = e;
        r.pat = 2'd0;
        r.exp = '{data: d, val: v, ls: l_s, le: l_e, fs: f_s, fe: f_e, busy: b};
        return r;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nfs, nfe, nb, bad;
        int fs_val[8];
        logic e_w;
        logic [1:0] p_w;
        logic found;

        tbl[0]  = mk(1'b1, 48'h0,            4'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1'b0, 48'h003002001000, 4'hF, 1, 0, 1, 0, 1);
        tbl[2]  = mk(1'b0, 48'h007006005004, 4'hF, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1'b0, 48'h000000009008, 4'h3, 0, 1, 0, 0, 1);
        tbl[4]  = mk(1'b0, 48'h0,            4'h0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1'b0, 48'h003002001000, 4'hF, 1, 0, 0, 0, 1);
        tbl[6]  = mk(1'b0, 48'h007006005004, 4'hF, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1'b0, 48'h000000009008, 4'h3, 0, 1, 0, 0, 1);
        tbl[8]  = mk(1'b0, 48'h0,            4'h0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(1'b0, 48'h003002001000, 4'hF, 1, 0, 0, 0, 1);
        tbl[10] = mk(1'b0, 48'h007006005004, 4'hF, 0, 0, 0, 0, 1);
        tbl[11] = mk(1'b0, 48'h000000009008, 4'h3, 0, 1, 0, 1, 1);
        for (int r = 12; r < 21; r++) tbl[r] = mk(1'b0, 48'h0, 4'h0, 0, 0, 0, 0, 1);
        tbl[21] = mk(1'b0, 48'h0,            4'h0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        resetAll();

        // Single frame, h-ramp, from the vector table
        for (int r = 0; r < 22; r++) begin
            applyStimulus(tbl[r].en, tbl[r].pat);
            checkOutput($sformatf("table_row%0d", r), tbl[r].exp);
        end

        // Back-to-back frames with frame-count pattern
        resetAll();
        applyStimulus(1'b1, 2'd3);
        checkOutput("b2b_launch", m_exp);
        nfs = 0; nfe = 0; nb = 0;
        for (int c = 0; c < 3 * FW; c++) begin
            applyStimulus(1'b1, 2'd3);
            checkOutput("b2b_stream", m_exp);
            if (fs) begin
                if (nfs < 8) fs_val[nfs] = int'(data[11:0]);
                nfs++;
            end
            if (fe) nfe++;
            if (busy) nb++;
        end
        checkBits("b2b_frame_starts", 64'(nfs), 64'd3);
        checkBits("b2b_frame_ends", 64'(nfe), 64'd3);
        checkBits("b2b_busy_cycles", 64'(nb), 64'(3 * FW));
        for (int f = 0; f < 3; f++) checkBits($sformatf("b2b_solid%0d", f), 64'(fs_val[f]), 64'(f));

        // Mid-frame toggling of en_i and pattern_i must not disturb the current frame
        bad = 0;
        for (int w = 0; w < FW; w++) begin
            e_w = (w == 0) ? 1'b1 : (w == FW - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            p_w = (w == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            applyStimulus(e_w, p_w);
            checkOutput("midframe_word", m_exp);
            if (val[0] && data[11:0] != 12'd3) bad++;
        end
        checkBits("midframe_solid_errors", 64'(bad), 64'd0);
        applyStimulus(1'b0, 2'd1);
        checkOutput("midframe_stop", m_exp);
        checkBits("midframe_idle_busy", 64'(busy), 64'd0);

        // Randomized run against the reference model
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
            checkOutput("random", m_exp);
        end

        // Asynchronous reset at x=1, y=1, then restart
        resetAll();
        applyStimulus(1'b1, 2'd0);
        for (int w = 0; w <= LW + 1; w++) begin
            applyStimulus(1'b0, 2'd0);
            checkOutput("pre_reset", m_exp);
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", '0);
        #1;
        rst = 1'b0;
        m_next = -1; m_fc = 0; m_pat = 2'd0;
        applyStimulus(1'b1, 2'd1);
        checkOutput("restart_launch", m_exp);
        applyStimulus(1'b0, 2'd1);
        checkOutput("restart_first", m_exp);
        checkBits("restart_frame_start", 64'(fs), 64'd1);
        for (int w = 1; w < FW + 2; w++) begin
            applyStimulus(1'b0, 2'd1);
            checkOutput("restart_stream", m_exp);
        end

        // Checkerboard on a 32-pixel-wide instance
        en2 = 1'b1;
        @(posedge clk);
        #1;
        en2 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge clk);
            #1;
            if (fs2) found = 1'b1;
        end
        checkBits("checker_frame_start_seen", 64'(found), 64'd1);
        if (found) begin
            for (int k = 0; k < 84; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                if ((k % 10) < 4 && (k < 10 || k >= 80)) begin
                    checkBits($sformatf("checker_word%0d", k), 64'(data2),
                              (((k % 10) >= 2) ^ (k >= 80)) ? 64'hFFFF_FFFF_FFFF : 64'h0);
                end
            end
        end

        // One word per active line: start and end markers coincide
        en3 = 1'b1;
        @(posedge clk);
        #1;
        en3 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge clk);
            #1;
            if (fs3) found = 1'b1;
        end
        checkBits("narrow_frame_start_seen", 64'(found), 64'd1);
        if (found) begin
            checkBits("narrow_row0", 64'({val3, ls3, le3, fs3, fe3}), 64'({4'hF, 4'b1110}));
            @(posedge clk);
            #1;
            checkBits("narrow_blank", 64'({val3, ls3, le3}), 64'd0);
            @(posedge clk);
            #1;
            checkBits("narrow_row1", 64'({val3, ls3, le3, fs3, fe3}), 64'({4'hF, 4'b1101}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
